// File: rtl/rw_write_arb_pkg.sv
// Shared types and constants for the write arbiter.
// Optional build macro (used by rw_write_arb): RW_WRITE_ARB_STATS_EN.
package swarm;

  localparam int unsigned N_RW_WRITERS = 4;
  localparam int unsigned RW_ADDR_W    = 32;
  localparam int unsigned RW_DATA_W    = 512;
  localparam int unsigned RW_STRB_W    = RW_DATA_W / 8;

  // One write request: address, full line data and byte strobes.
  typedef struct packed {
    logic [RW_ADDR_W-1:0] addr;
    logic [RW_DATA_W-1:0] data;
    logic [RW_STRB_W-1:0] strb;
  } rw_wr_req_t;

endpackage

// File: rtl/rw_write_arb_if.sv
// Requester-side and data-array-side handshake bundle of the write arbiter.
interface rw_write_arb_if
  import swarm::*;
#(
  parameter int unsigned N_REQ = N_RW_WRITERS
);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     req_prio;
  rw_wr_req_t           req_wr [N_REQ];
  logic                 wvalid;
  logic                 wready;
  logic [RW_ADDR_W-1:0] waddr;
  logic [RW_DATA_W-1:0] wdata;
  logic [RW_STRB_W-1:0] wstrb;

  // Arbiter view.
  modport master (
    input  req_valid, req_prio, req_wr, wready,
    output req_ready, wvalid, waddr, wdata, wstrb
  );

  // Requester / data-array view.
  modport slave (
    output req_valid, req_prio, req_wr, wready,
    input  req_ready, wvalid, waddr, wdata, wstrb
  );

endinterface

// File: rtl/rw_write_arb_rr_pick.sv
// Round-robin picker: lowest candidate index at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         cand,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W:0] pos;
  logic           found;

  // Scan N_REQ positions starting at ptr and take the first candidate.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      if (!found && cand[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        idx                     = pos[IDX_W-1:0];
        grant[pos[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rw_write_arb.sv
// Write arbiter: N requesters with a priority class and starvation guard,
// feeding a single registered write slot toward the data array.
// Build macro RW_WRITE_ARB_STATS_EN enables per-requester grant counters.
module rw_write_arb
  import swarm::*;
#(
  parameter int unsigned N_REQ = N_RW_WRITERS,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  rw_write_arb_if.master         bus,
  input  logic [CNT_W-1:0]       starve_limit,
  output logic [N_REQ-1:0][31:0] stat_grants,
  input  logic                   stat_clear
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic             wvalid_q, wvalid_d;
  rw_wr_req_t       pay_q, pay_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic [N_REQ-1:0] prio_v_c, norm_v_c, cand_c, grant_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             slot_free_c, force_norm_c, accept_c;

  // Candidate selection: prio class first unless the normal class is starved.
  always_comb begin
    prio_v_c     = bus.req_valid & bus.req_prio;
    norm_v_c     = bus.req_valid & ~bus.req_prio;
    slot_free_c  = !wvalid_q || bus.wready;
    force_norm_c = (starve_limit != '0) && (starve_q >= starve_limit) && (|norm_v_c);
    cand_c       = '0;
    if (slot_free_c && rstn) begin
      if (force_norm_c)    cand_c = norm_v_c;
      else if (|prio_v_c)  cand_c = prio_v_c;
      else                 cand_c = norm_v_c;
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .cand  (cand_c),
    .ptr   (rr_ptr_q),
    .grant (grant_c),
    .idx   (pick_idx_c)
  );

  assign accept_c      = |grant_c;
  assign bus.req_ready = grant_c;

  // Next-state for output slot, round-robin pointer and starvation counter.
  always_comb begin
    wvalid_d = wvalid_q;
    pay_d    = pay_q;
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    if (accept_c) begin
      wvalid_d = 1'b1;
      pay_d    = bus.req_wr[pick_idx_c];
      rr_ptr_d = (pick_idx_c == IDX_W'(N_REQ-1)) ? '0 : pick_idx_c + IDX_W'(1);
      if (!bus.req_prio[pick_idx_c])                 starve_d = '0;
      else if ((|norm_v_c) && starve_q < starve_limit) starve_d = starve_q + CNT_W'(1);
    end else if (bus.wready) begin
      wvalid_d = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wvalid_q <= 1'b0;
      rr_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      wvalid_q <= wvalid_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Payload register; contents are meaningless while wvalid is low.
  always_ff @(posedge clk) begin
    pay_q <= pay_d;
  end

  assign bus.wvalid = wvalid_q;
  assign bus.waddr  = pay_q.addr;
  assign bus.wdata  = pay_q.data;
  assign bus.wstrb  = pay_q.strb;

`ifdef RW_WRITE_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] stat_q, stat_d;

  // Per-requester accept counters; clear wins over increment.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (stat_clear)      stat_d[i] = '0;
      else if (grant_c[i]) stat_d[i] = stat_q[i] + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rstn) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_grants = stat_q;
`else
  logic stat_clear_unused;
  assign stat_clear_unused = stat_clear;
  assign stat_grants       = '0;
`endif

endmodule
